sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO that generalises the team's dual-clock FIFO for same-domain buffering. Width, depth and the programmable almost-full/almost-empty thresholds are set by parameters. Adds an occupancy count, a first-word-fall-through (FWFT) read mode, single-cycle overflow/underflow pulses with sticky error bits, and a synchronous flush. Sits between producer/consumer blocks sharing one clock.

---
 rtl/sync_fifo_param.sv | 152 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// overflow/underflow pulses with sticky bits, synchronous flush and optional FWFT read.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       ovf_sticky,
  output logic                       udf_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              ovf_stk_q, ovf_stk_d;
  logic              udf_stk_q, udf_stk_d;

  logic              rd_ok;
  logic              wr_ok;
  logic              mem_we;

  // A read frees a slot in the same edge, so a full FIFO can still take a write.
  assign rd_ok  = rd & ~empty_q;
  assign wr_ok  = wr & (~full_q | rd_ok);
  assign mem_we = wr_ok & ~flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    full_d    = full_q;
    empty_d   = empty_q;
    afull_d   = afull_q;
    aempty_d  = aempty_q;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;
    ovf_stk_d = ovf_stk_q;
    udf_stk_d = udf_stk_q;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rdata_d   = '0;
      full_d    = 1'b0;
      empty_d   = 1'b1;
      afull_d   = 1'b0;
      aempty_d  = 1'b1;
      ovf_stk_d = 1'b0;
      udf_stk_d = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rdata_d  = mem_q[rd_ptr_q];
      end
      count_d   = count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
      // Flags come from the next count so they line up with the count register.
      full_d    = (count_d == CW'(DEPTH));
      empty_d   = (count_d == '0);
      afull_d   = (count_d >= CW'(AF_LEVEL));
      aempty_d  = (count_d <= CW'(AE_LEVEL));
      ovf_d     = wr & ~wr_ok;
      udf_d     = rd & ~rd_ok;
      ovf_stk_d = ovf_stk_q | ovf_d;
      udf_stk_d = udf_stk_q | udf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ovf_stk_q <= 1'b0;
      udf_stk_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      ovf_stk_q <= ovf_stk_d;
      udf_stk_q <= udf_stk_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = empty_q ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      assign rdata = rdata_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign ovf_sticky   = ovf_stk_q;
  assign udf_sticky   = udf_stk_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a registered-read and an FWFT instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AF_A  = DEPTH - 2;
  localparam int AE_A  = 2;
  localparam int AF_B  = 3;
  localparam int AE_B  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, wr, rd;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rdata_a, rdata_b;
  logic          full_a, empty_a, af_a, ae_a, ovf_a, udf_a, os_a, us_a;
  logic          full_b, empty_b, af_b, ae_b, ovf_b, udf_b, os_b, us_b;
  logic [CW-1:0] count_a, count_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata;
  logic          m_ovf, m_udf, m_os, m_us;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr), .rd(rd), .wdata(wdata),
    .rdata(rdata_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a),
    .ovf_sticky(os_a), .udf_sticky(us_a)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF_B), .AE_LEVEL(AE_B), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr), .rd(rd), .wdata(wdata),
    .rdata(rdata_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b),
    .ovf_sticky(os_b), .udf_sticky(us_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_ovf = 1'b0; m_udf = 1'b0; m_os = 1'b0; m_us = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
    bit rok, wok;
    if (f) begin
      model_reset();
    end else begin
      rok = r && (q.size() > 0);
      wok = w && ((q.size() < DEPTH) || rok);
      if (rok) m_rdata = q.pop_front();
      if (wok) q.push_back(d);
      m_ovf = w && !wok;
      m_udf = r && !rok;
      m_os  = m_os | m_ovf;
      m_us  = m_us | m_udf;
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("a_rdata",   32'(rdata_a), 32'(m_rdata));
    chk("a_count",   32'(count_a), 32'(n));
    chk("a_full",    32'(full_a),  32'(n == DEPTH));
    chk("a_empty",   32'(empty_a), 32'(n == 0));
    chk("a_afull",   32'(af_a),    32'(n >= AF_A));
    chk("a_aempty",  32'(ae_a),    32'(n <= AE_A));
    chk("a_ovf",     32'(ovf_a),   32'(m_ovf));
    chk("a_udf",     32'(udf_a),   32'(m_udf));
    chk("a_ovf_stk", 32'(os_a),    32'(m_os));
    chk("a_udf_stk", 32'(us_a),    32'(m_us));
    chk("b_count",   32'(count_b), 32'(n));
    chk("b_full",    32'(full_b),  32'(n == DEPTH));
    chk("b_empty",   32'(empty_b), 32'(n == 0));
    chk("b_afull",   32'(af_b),    32'(n >= AF_B));
    chk("b_aempty",  32'(ae_b),    32'(n <= AE_B));
    chk("b_ovf",     32'(ovf_b),   32'(m_ovf));
    chk("b_udf",     32'(udf_b),   32'(m_udf));
    chk("b_ovf_stk", 32'(os_b),    32'(m_os));
    chk("b_udf_stk", 32'(us_b),    32'(m_us));
    if (n > 0) chk("b_rdata_head", 32'(rdata_b), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
    wr = w; rd = r; flush = f; wdata = d;
    @(posedge clk);
    model_edge(w, r, f, d);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Plan 1: fill 0..7
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
    // Plan 2: three rejected writes, then drain in order
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'hEE);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    // Plan 3: underflow on empty, then rd+wr on empty
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'hA5);
    // Plan 4: full with simultaneous rd+wr
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h55);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    // Plan 5: FWFT head visibility
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b0, 8'h22);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    // Plan 6: build count=5 with both sticky bits, then flush with wr
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h30 + i));
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h77);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      logic w, r, f;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 63) == 0);
      step(w, r, f, DW'($urandom));
    end

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom));
    wr = 1'b1; wdata = 8'h9C;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    wr = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
